keypad_hex_entry: RTL and testbench
===================================

Name: keypad_hex_entry

Overview:
- Scans a 4x4 matrix keypad, debounces key presses and assembles the hex digits into a 16-bit word.
- Each new digit is shifted in from the right, so the word reads like a calculator entry.
- This is the input-side counterpart to the 7-segment display path: `dout`/`w_display` feed the display's `din`/`w_display` directly.
- Sits on the board clock next to the display block.

Parameters:
- SCAN_DIV, 5000, clock cycles each row is driven; legal range >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; legal range 1..255.

Ports:
- extclk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- col  input  4  keypad column lines; pulled up, 0 = pressed; asynchronous to extclk
- clr  input  1  synchronous clear of the entered word
- row  output  4  keypad row drive; exactly one bit is 0 (active row), the others are 1
- dout  output  16  assembled hex word
- w_display  output  1  1-cycle pulse whenever `dout` changes
- key_valid  output  1  1-cycle pulse on an accepted key press
- key_code  output  4  code of the last accepted key

Behaviour:
- Reset (`reset`=0 sampled on an `extclk` edge):
  - row=4'b1110; dout=0; key_code=0; w_display=0; key_valid=0.
  - FSM in IDLE; all counters and synchronizers cleared.
- col synchronizer: `col` passes through a 2-FF synchronizer before any use.
- Row scan:
  - A slot counter runs 0..SCAN_DIV-1.
  - The row index r (0..3) advances when the counter wraps and wraps 3->0.
  - row = ~(4'b0001 << r).
  - Synchronized `col` is sampled only in slot cycle SCAN_DIV-1 of each row (settling margin).
- Key map (row,col) -> code:
  - r0: c0=1, c1=2, c2=3, c3=A
  - r1: c0=4, c1=5, c2=6, c3=B
  - r2: c0=7, c1=8, c2=9, c3=C
  - r3: c0=0, c1=F, c2=E, c3=D
- Scan evaluation happens in the last cycle of the row-3 slot. The full scan is classified as:
  - EMPTY: no zeros sampled.
  - SINGLE(code): exactly one zero across all 16 samples.
  - MULTI: two or more zeros.
  - Scan period = 4*SCAN_DIV cycles.
- FSM (state changes only at scan evaluation):
  - IDLE:
    - SINGLE(k) -> DEBOUNCE; cand=k; cnt=1.
    - If DEBOUNCE_SCANS=1, go directly to HELD with acceptance.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS -> accept, go to HELD.
    - SINGLE(other) -> restart with the new cand, cnt=1.
    - EMPTY or MULTI -> IDLE.
  - HELD:
    - EMPTY -> RELEASE; cnt=1.
    - SINGLE or MULTI -> stay. No auto-repeat.
  - RELEASE:
    - EMPTY -> cnt++; reaching DEBOUNCE_SCANS -> IDLE.
    - Any non-EMPTY scan -> HELD.
- Accept:
  - In the cycle after the evaluation: key_valid=1, w_display=1, key_code=cand, dout={dout[11:0],cand}.
  - The upper nibble is discarded; no saturation or overflow flag.
  - The pulses last exactly one cycle.
- clr=1:
  - Next cycle: dout=0 and w_display=1.
  - key_code, FSM and scan state are unaffected.
  - If clr coincides with an accept cycle, clr wins: dout=0, w_display=1, key_valid=1, key_code updated, digit dropped.
  - clr held high clears every cycle and pulses w_display every cycle.
- Reset mid-scan or mid-debounce returns to the reset state the next cycle; partially debounced keys are discarded.
- Latency: a clean press stable from the start of a scan is accepted DEBOUNCE_SCANS scans later, +1 cycle, +2 cycles of synchronizer delay on `col`.

Test Plan:
- Reset: SCAN_DIV=4, DEBOUNCE_SCANS=3; hold `reset`=0 for 5 cycles -> row=1110, dout=0000, both pulses 0. Release -> row steps 1110, 1101, 1011, 0111 every 4 cycles, then wraps.
- Single key entry: keypad model presses (r1,c2) for 10 scans, then releases for 5 scans -> exactly one key_valid pulse with key_code=6; dout=0006; w_display pulses together with key_valid.
- Word assembly and wrap: press and release 1, 2, A, F, 7 in sequence -> dout goes 0001, 0012, 012A, 12AF, 2AF7.
- Bounce and ghosting:
  - Key 5 toggling every scan for 8 scans -> no key_valid.
  - Keys 5 and 9 held simultaneously -> no key_valid.
  - Key 3 held for 50 scans -> exactly one key_valid.
- clr collision: dout=1234. Drive clr=1 for one cycle aligned with the accept cycle of key 8 -> dout=0000, key_valid=1, key_code=8, one w_display pulse.
- Reset mid-debounce: press C, then drive `reset`=0 after 2 scans, then release reset with C still held -> dout stays 0000 until 3 fresh scans complete; then dout=000C.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner with scan-level debounce. Accepted hex digits are
// shifted into a 16-bit calculator-style entry word for the 7-segment path.
module keypad_hex_entry #(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        extclk,
  input  logic        reset,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [15:0] dout,
  output logic        w_display,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int unsigned      SlotW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [7:0]       DebLast  = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

  // (row, col) -> hex code of the key at that crossing
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]       col_meta_q, col_sync_q;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [1:0]       row_idx_q, row_idx_d;
  // Zero count across rows already sampled this scan, saturating at 2 (MULTI)
  logic [1:0]       zeros_q, zeros_d;
  logic [3:0]       hit_q, hit_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      dout_q, dout_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             w_display_q, w_display_d;

  logic       sample, scan_end;
  logic [1:0] row_zeros, scan_zeros;
  logic [3:0] row_code, scan_code;
  logic [2:0] zero_sum;
  logic       is_empty, is_single, accept;
  logic [7:0] cnt_inc;

  assign row       = ~(4'b0001 << row_idx_q);
  assign dout      = dout_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign w_display = w_display_q;

  // Decode the synchronized columns of the active row and fold them into the scan totals
  always_comb begin
    row_zeros = 2'd0;
    row_code  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync_q[c]) begin
        if (row_zeros != 2'd2) row_zeros = row_zeros + 2'd1;
        row_code = key_map(row_idx_q, 2'(c));
      end
    end
    zero_sum   = {1'b0, zeros_q} + {1'b0, row_zeros};
    scan_zeros = (zero_sum >= 3'd2) ? 2'd2 : zero_sum[1:0];
    // With exactly one zero overall, it came from either this row or an earlier one
    scan_code  = (row_zeros != 2'd0) ? row_code : hit_q;
    is_empty   = (scan_zeros == 2'd0);
    is_single  = (scan_zeros == 2'd1);
  end

  // Row slot timing and per-scan accumulation
  always_comb begin
    sample    = (slot_q == SlotLast);
    scan_end  = sample && (row_idx_q == 2'd3);
    slot_d    = sample ? '0 : slot_q + SlotW'(1);
    row_idx_d = sample ? row_idx_q + 2'd1 : row_idx_q;
    zeros_d   = zeros_q;
    hit_d     = hit_q;
    if (scan_end) begin
      zeros_d = 2'd0;
      hit_d   = 4'h0;
    end else if (sample) begin
      zeros_d = scan_zeros;
      hit_d   = scan_code;
    end
  end

  // Debounce FSM; only moves at scan evaluation
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cnt_inc = cnt_q + 8'd1;
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (is_single) begin
            cand_d = scan_code;
            cnt_d  = 8'd1;
            if (DebLast == 8'd1) begin
              accept  = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (is_single) begin
            if (scan_code == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DebLast) begin
                accept  = 1'b1;
                state_d = StHeld;
              end
            end else begin
              cand_d = scan_code;
              cnt_d  = 8'd1;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (is_empty) begin
            cnt_d   = 8'd1;
            state_d = (DebLast == 8'd1) ? StIdle : StRelease;
          end
        end
        StRelease: begin
          if (is_empty) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebLast) state_d = StIdle;
          end else begin
            state_d = StHeld;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output word and pulses; clr takes priority over a digit shift in the same cycle
  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? scan_code : key_code_q;
    w_display_d = accept | clr;
    dout_d      = dout_q;
    if (clr) begin
      dout_d = 16'h0000;
    end else if (accept) begin
      dout_d = {dout_q[11:0], scan_code};
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge extclk) begin
    if (!reset) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      slot_q      <= '0;
      row_idx_q   <= 2'd0;
      zeros_q     <= 2'd0;
      hit_q       <= 4'h0;
      state_q     <= StIdle;
      cand_q      <= 4'h0;
      cnt_q       <= 8'd0;
      dout_q      <= 16'h0000;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      w_display_q <= 1'b0;
    end else begin
      col_meta_q  <= col;
      col_sync_q  <= col_meta_q;
      slot_q      <= slot_d;
      row_idx_q   <= row_idx_d;
      zeros_q     <= zeros_d;
      hit_q       <= hit_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      w_display_q <= w_display_d;
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a keypad model drives col from row, and a
// scan-level reference model predicts accepted keys, dout and pulse counts.
module tb_keypad_hex_entry;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned DebScans = 3;
  localparam int          ScanLen  = 4 * ScanDiv;

  logic        extclk = 1'b0;
  logic        reset  = 1'b0;
  logic        clr    = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] dout;
  logic        w_display;
  logic        key_valid;
  logic [3:0]  key_code;

  // Pressed keys, bit index = r*4 + c
  logic [15:0] press = 16'h0000;

  int errors = 0;
  int checks = 0;
  int kv_seen = 0;
  int wd_seen = 0;

  // Reference model state
  bit          armed;
  int          run_len;
  int          empty_run;
  logic [3:0]  run_code;
  logic [3:0]  m_code;
  logic [15:0] m_dout;
  bit          m_accept;
  int          exp_kv = 0;
  int          exp_wd = 0;

  keypad_hex_entry #(
    .SCAN_DIV      (ScanDiv),
    .DEBOUNCE_SCANS(DebScans)
  ) dut (
    .extclk   (extclk),
    .reset    (reset),
    .col      (col),
    .clr      (clr),
    .row      (row),
    .dout     (dout),
    .w_display(w_display),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  initial forever #5 extclk = ~extclk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  always @(negedge extclk) begin
    if (reset) begin
      if (key_valid) kv_seen++;
      if (w_display) wd_seen++;
    end
  end

  function automatic logic [3:0] code_of(input int idx);
    logic [3:0] tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    return tbl[idx];
  endfunction

  function automatic logic [15:0] kb(input logic [3:0] code);
    logic [15:0] m = 16'h0000;
    for (int i = 0; i < 16; i++) if (code_of(i) == code) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    armed     = 1'b1;
    run_len   = 0;
    empty_run = 0;
    run_code  = 4'h0;
    m_code    = 4'h0;
    m_dout    = 16'h0000;
    m_accept  = 1'b0;
  endtask

  // One full scan: a key is accepted after DebScans identical single-key scans,
  // and re-armed only after DebScans empty scans.
  task automatic model_scan(input logic [15:0] keys, input int clr_at);
    int         n;
    logic [3:0] k;
    n = $countones(keys);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (keys[i]) k = code_of(i);
    m_accept = 1'b0;
    if (clr_at >= 0) m_dout = 16'h0000;
    if (armed) begin
      if (n == 1) begin
        if (run_len > 0 && run_code == k) run_len++;
        else run_len = 1;
        run_code = k;
        if (run_len == DebScans) begin
          m_accept  = 1'b1;
          armed     = 1'b0;
          empty_run = 0;
        end
      end else begin
        run_len = 0;
      end
    end else if (n == 0) begin
      empty_run++;
      if (empty_run == DebScans) begin
        armed   = 1'b1;
        run_len = 0;
      end
    end else begin
      empty_run = 0;
    end
    if (m_accept) begin
      m_code = k;
      exp_kv++;
      if (clr_at != ScanLen - 1) begin
        m_dout = {m_dout[11:0], k};
        exp_wd++;
      end
    end
    if (clr_at >= 0) exp_wd++;
  endtask

  // Run one scan with the given keys held; optionally pulse clr in cycle clr_at
  task automatic do_scan(input logic [15:0] keys, input int clr_at);
    press = keys;
    for (int i = 0; i < ScanLen; i++) begin
      clr = (i == clr_at);
      @(posedge extclk);
      #1;
      clr = 1'b0;
      if (i == clr_at && i != ScanLen - 1) begin
        check("clr_dout", 32'(dout), 32'h0);
        check("clr_wdisp", 32'(w_display), 32'h1);
      end
    end
    model_scan(keys, clr_at);
    check("key_valid", 32'(key_valid), 32'(m_accept));
    check("w_display", 32'(w_display), 32'(m_accept || clr_at == ScanLen - 1));
    check("dout", 32'(dout), 32'(m_dout));
    check("key_code", 32'(key_code), 32'(m_code));
  endtask

  task automatic check_counts(input string tag);
    @(negedge extclk);
    #1;
    check({tag, "_kv_count"}, 32'(kv_seen), 32'(exp_kv));
    check({tag, "_wd_count"}, 32'(wd_seen), 32'(exp_wd));
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge extclk);
    #1;
    check("rst_row", 32'(row), 32'(4'b1110));
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_w_display", 32'(w_display), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0]  er;
    logic [3:0]  digits [5] = '{4'h1, 4'h2, 4'hA, 4'hF, 4'h7};
    logic [15:0] words  [5] = '{16'h0001, 16'h0012, 16'h012A, 16'h12AF, 16'h2AF7};
    logic [3:0]  d1234  [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    int          pat, hold, ka, kb2, cat;
    logic [15:0] keys;

    model_reset();
    apply_reset(5);

    // Row walk over two idle scans
    for (int i = 0; i < 2 * ScanLen; i++) begin
      er = ~(4'b0001 << ((i / ScanDiv) % 4));
      check("row_walk", 32'(row), 32'(er));
      @(posedge extclk);
      #1;
    end
    model_scan(16'h0000, -1);
    model_scan(16'h0000, -1);

    // Single key 6
    repeat (10) do_scan(kb(4'h6), -1);
    repeat (5) do_scan(16'h0000, -1);
    check("single_dout", 32'(dout), 32'h0006);
    check("single_code", 32'(key_code), 32'h6);
    check_counts("single");

    // Word assembly from cleared entry
    do_scan(16'h0000, 5);
    for (int j = 0; j < 5; j++) begin
      repeat (4) do_scan(kb(digits[j]), -1);
      repeat (4) do_scan(16'h0000, -1);
      check("word", 32'(dout), 32'(words[j]));
    end
    check_counts("word");

    // Bounce, ghosting, long hold
    for (int i = 0; i < 8; i++) do_scan((i % 2 == 0) ? kb(4'h5) : 16'h0000, -1);
    repeat (6) do_scan(kb(4'h5) | kb(4'h9), -1);
    repeat (4) do_scan(16'h0000, -1);
    check("bounce_dout", 32'(dout), 32'h2AF7);
    check_counts("bounce");
    repeat (50) do_scan(kb(4'h3), -1);
    repeat (4) do_scan(16'h0000, -1);
    check("hold_dout", 32'(dout), 32'hAF73);
    check_counts("hold");

    // clr colliding with the accept of key 8
    do_scan(16'h0000, 3);
    for (int j = 0; j < 4; j++) begin
      repeat (3) do_scan(kb(d1234[j]), -1);
      repeat (4) do_scan(16'h0000, -1);
    end
    check("pre_clr_dout", 32'(dout), 32'h1234);
    check_counts("pre_clr");
    repeat (2) do_scan(kb(4'h8), -1);
    do_scan(kb(4'h8), ScanLen - 1);
    check("coll_kv", 32'(key_valid), 32'h1);
    check("coll_code", 32'(key_code), 32'h8);
    check("coll_dout", 32'(dout), 32'h0000);
    check_counts("coll");
    repeat (4) do_scan(16'h0000, -1);

    // Reset mid-debounce with C held throughout
    repeat (2) do_scan(kb(4'hC), -1);
    press = kb(4'hC);
    repeat (7) @(posedge extclk);
    apply_reset(5);
    repeat (2) do_scan(kb(4'hC), -1);
    check("rstmid_early", 32'(dout), 32'h0000);
    do_scan(kb(4'hC), -1);
    check("rstmid_dout", 32'(dout), 32'h000C);
    repeat (4) do_scan(16'h0000, -1);
    check_counts("rstmid");

    // Random key patterns with occasional clr
    for (int p = 0; p < 40; p++) begin
      pat  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 5));
      ka   = int'($urandom_range(0, 15));
      kb2  = (ka + 1 + int'($urandom_range(0, 14))) % 16;
      keys = 16'h0000;
      if (pat >= 3) keys[ka] = 1'b1;
      if (pat == 9) keys[kb2] = 1'b1;
      for (int h = 0; h < hold; h++) begin
        cat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ScanLen - 1)) : -1;
        do_scan(keys, cat);
      end
    end
    repeat (4) do_scan(16'h0000, -1);
    check_counts("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
